prog_mem_arbiter: RTL and testbench
===================================

# prog_mem_arbiter

Sequencer and arbiter for the program-memory port. It shares the single program-memory bank between the CPU fetch unit and the program loader/debug port. It decodes each 32-bit byte address against the program window 0x31B0–0x35AF and drives chip-select plus the 10-bit local offset. Out-of-window or unaligned accesses are answered with a fault and never reach memory.

## Interface
Parameters:
- BASE_ADDR, 32'h31B0: first byte address of the program window.
- LIMIT_ADDR, 32'h35AF: last byte address of the program window, inclusive.
- OFFS_W, 10: width of the local offset sent to memory.
- MAX_FETCH_STREAK, 4: consecutive fetch grants allowed while the loader waits.

Ports:
- clk  in  1: single clock; all logic rising-edge.
- rst  in  1: synchronous reset, active-high.
- f_req  in  1: fetch request; held until f_ack.
- f_addr  in  32: fetch byte address; stable while f_req is high.
- f_ack  out  1: one-cycle fetch completion pulse.
- f_rdata  out  32: fetch read data; valid when f_ack is high.
- f_fault  out  1: fetch fault; qualified by f_ack.
- l_req  in  1: loader request; held until l_ack.
- l_we  in  1: loader write enable; 1 = write, 0 = read.
- l_addr  in  32: loader byte address.
- l_wdata  in  32: loader write data.
- l_ack  out  1: one-cycle loader completion pulse.
- l_rdata  out  32: loader read data; valid when l_ack is high, 0 on writes.
- l_fault  out  1: loader fault; qualified by l_ack.
- mem_cs  out  1: program-memory chip select, registered.
- mem_we  out  1: program-memory write enable, registered.
- mem_addr  out  OFFS_W: byte offset, addr − BASE_ADDR, low OFFS_W bits, registered.
- mem_wdata  out  32: write data, registered.
- mem_rdata  in  32: memory read data, valid the cycle after mem_cs.
- busy  out  1: high whenever state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate.
  - ISSUE: memory cycle.
  - RESP: acknowledge.
- IDLE → ISSUE when f_req or l_req is high; the winner, address, we and wdata are latched.
- ISSUE → RESP unconditionally.
- RESP → IDLE unconditionally.
- Decode, applied to the latched address:
  - in_range = BASE_ADDR ≤ addr ≤ LIMIT_ADDR.
  - aligned = addr[1:0] == 0.
  - ok = in_range & aligned.
- ISSUE with ok: mem_cs = 1, mem_we = latched we (always 0 for fetch), mem_addr = (addr − BASE_ADDR)[OFFS_W−1:0], mem_wdata = latched wdata.
- ISSUE with !ok: mem_cs = 0, mem_we = 0; the fault flag is latched.
- RESP: the winner's ack = 1 and fault = latched flag.
  - rdata = mem_rdata for an ok read.
  - rdata = 0 for a write or a fault.
  - The other requester's ack stays 0.
- Arbitration:
  - Fetch has fixed priority, except when streak == MAX_FETCH_STREAK and l_req is high; then the loader wins.
  - streak (3-bit saturating) increments on a fetch grant taken while l_req is high.
  - streak clears on a loader grant, and on any arbitration where l_req is low.
- Simultaneous new request and RESP: a request is only sampled in IDLE. A requester may keep req high after its ack with a new address; that counts as a new transaction.

## Timing
- Reset, effective at the first rising edge with rst high:
  - state = IDLE, streak = 0.
  - All outputs 0: f_ack, l_ack, f_fault, l_fault, f_rdata, l_rdata, mem_cs, mem_we, mem_addr, mem_wdata, busy.
- Reset mid-transaction aborts it: no ack is issued, and mem_cs drops on the next edge.
- Request seen high in IDLE at cycle t:
  - t+1: ISSUE (mem_cs).
  - t+2: RESP (ack).
  - t+3: IDLE.
- Latency is 2 cycles from the sampled request to ack. Throughput is one transaction per 3 cycles.
- Faults take identical timing, with no memory access.
- mem_cs is exactly one cycle wide. ack is exactly one cycle wide.
- A req dropped before its ack is a protocol violation. The latched transaction still completes.

## Test plan
- Fetch read at 0x31B0 after reset → mem_cs high at t+1 with mem_addr = 0x000; f_ack at t+2 with f_rdata = mem_rdata, f_fault = 0.
- Fetch sweep 0x31B0 to 0x35AF step 4 → mem_addr 0x000…0x3FC sequentially; no faults; 256 acks, each 3 cycles apart.
- Fetch at 0x31AC, 0x35B0, and 0x31B2 → mem_cs never high; f_ack with f_fault = 1 and f_rdata = 0 at t+2.
- Loader write 0x3200 with data 0xDEADBEEF → mem_we = 1, mem_addr = 0x050, mem_wdata = 0xDEADBEEF; l_ack with l_rdata = 0.
- f_req and l_req held high continuously → grant order F,F,F,F,L,F,F,F,F,L…
- rst asserted during ISSUE → next edge mem_cs = 0, busy = 0, no ack; after release a pending f_req is served normally.

Source files
------------

// File: rtl/prog_mem_arbiter.sv
// prog_mem_arbiter
// Shares the single program-memory bank between the CPU fetch unit and the
// loader/debug port. Each accepted request takes IDLE -> ISSUE -> RESP, so
// there is one transaction every three cycles. The latched byte address is
// decoded against the program window. Accesses that are out of window or
// unaligned never assert mem_cs and are answered with a fault instead.

module prog_mem_arbiter #(
    parameter logic [31:0] BASE_ADDR        = 32'h0000_31B0,
    parameter logic [31:0] LIMIT_ADDR       = 32'h0000_35AF,
    parameter int          OFFS_W           = 10,
    parameter int          MAX_FETCH_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              f_req,
    input  logic [31:0]       f_addr,
    output logic              f_ack,
    output logic [31:0]       f_rdata,
    output logic              f_fault,
    // loader / debug port
    input  logic              l_req,
    input  logic              l_we,
    input  logic [31:0]       l_addr,
    input  logic [31:0]       l_wdata,
    output logic              l_ack,
    output logic [31:0]       l_rdata,
    output logic              l_fault,
    // program memory
    output logic              mem_cs,
    output logic              mem_we,
    output logic [OFFS_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    // status
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [2:0] MAX_S = 3'(MAX_FETCH_STREAK);

    // Window decode: the address must lie inside the window and be word aligned
    function automatic logic addr_ok(input logic [31:0] a);
        addr_ok = (a >= BASE_ADDR) && (a <= LIMIT_ADDR) && (a[1:0] == 2'b00);
    endfunction

    // Local byte offset inside the window
    function automatic logic [OFFS_W-1:0] addr_offs(input logic [31:0] a);
        addr_offs = OFFS_W'(a - BASE_ADDR);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_streak;
    logic [2:0]          w_streak_nxt;

    logic                r_win_l;      // 1 = loader owns the current transaction
    logic                r_we;
    logic                r_fault;
    logic                r_rd_ok;      // RESP carries valid read data

    logic                r_mem_cs;
    logic                r_mem_we;
    logic [OFFS_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_f_ack;
    logic                r_l_ack;
    logic                r_f_fault;
    logic                r_l_fault;

    logic                w_any_req;
    logic                w_grant_l;
    logic [31:0]         w_sel_addr;
    logic                w_sel_we;
    logic [31:0]         w_sel_wdata;
    logic                w_sel_ok;

    // Arbitration: fetch wins unless the loader has waited through a full streak
    always_comb begin
        w_any_req   = f_req | l_req;
        w_grant_l   = l_req && (!f_req || (r_streak == MAX_S));
        w_sel_addr  = 32'h0000_0000;
        w_sel_we    = 1'b0;
        w_sel_wdata = 32'h0000_0000;
        if (w_grant_l) begin
            w_sel_addr  = l_addr;
            w_sel_we    = l_we;
            w_sel_wdata = l_wdata;
        end else begin
            w_sel_addr  = f_addr;
            w_sel_we    = 1'b0;
            w_sel_wdata = 32'h0000_0000;
        end
        w_sel_ok = addr_ok(w_sel_addr);
    end

    // Next-state and fetch-streak logic
    always_comb begin
        w_state_nxt  = r_state;
        w_streak_nxt = r_streak;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
                if (!l_req || w_grant_l) begin
                    w_streak_nxt = 3'd0;
                end else if (r_streak == 3'd7) begin
                    w_streak_nxt = 3'd7;
                end else begin
                    w_streak_nxt = r_streak + 3'd1;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_streak_nxt = 3'd0;
            end
        endcase
    end

    // State and streak registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_streak <= 3'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    // Transaction latch, memory strobes and acknowledge pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_win_l     <= 1'b0;
            r_we        <= 1'b0;
            r_fault     <= 1'b0;
            r_rd_ok     <= 1'b0;
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {OFFS_W{1'b0}};
            r_mem_wdata <= 32'h0000_0000;
            r_f_ack     <= 1'b0;
            r_l_ack     <= 1'b0;
            r_f_fault   <= 1'b0;
            r_l_fault   <= 1'b0;
        end else begin
            // strobes are single-cycle; each state re-asserts only what it owns
            r_mem_cs    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= {OFFS_W{1'b0}};
            r_mem_wdata <= 32'h0000_0000;
            r_f_ack     <= 1'b0;
            r_l_ack     <= 1'b0;
            r_f_fault   <= 1'b0;
            r_l_fault   <= 1'b0;
            r_rd_ok     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_win_l <= w_grant_l;
                        r_we    <= w_sel_we;
                        r_fault <= !w_sel_ok;
                        if (w_sel_ok) begin
                            r_mem_cs    <= 1'b1;
                            r_mem_we    <= w_sel_we;
                            r_mem_addr  <= addr_offs(w_sel_addr);
                            r_mem_wdata <= w_sel_wdata;
                        end else begin
                            r_mem_cs    <= 1'b0;
                            r_mem_we    <= 1'b0;
                        end
                    end else begin
                        r_win_l <= r_win_l;
                    end
                end
                ST_ISSUE: begin
                    r_f_ack   <= !r_win_l;
                    r_l_ack   <= r_win_l;
                    r_f_fault <= !r_win_l && r_fault;
                    r_l_fault <= r_win_l && r_fault;
                    r_rd_ok   <= !r_fault && !r_we;
                end
                ST_RESP: begin
                    r_rd_ok <= 1'b0;
                end
                default: begin
                    r_win_l <= 1'b0;
                    r_we    <= 1'b0;
                    r_fault <= 1'b0;
                end
            endcase
        end
    end

    // memory read data arrives during RESP, so it is steered straight to the winner
    assign f_rdata   = (r_f_ack && r_rd_ok) ? mem_rdata : 32'h0000_0000;
    assign l_rdata   = (r_l_ack && r_rd_ok) ? mem_rdata : 32'h0000_0000;
    assign f_ack     = r_f_ack;
    assign l_ack     = r_l_ack;
    assign f_fault   = r_f_fault;
    assign l_fault   = r_l_fault;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Scoreboard bench for prog_mem_arbiter. Stimulus pushes the expected memory
// cycle and acknowledge (with the cycle each must appear in); a monitor pops
// and compares whenever mem_cs or an ack is seen.

module tb_prog_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic [31:0] f_rdata;
    logic        f_fault;
    logic        l_req;
    logic        l_we;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic        l_ack;
    logic [31:0] l_rdata;
    logic        l_fault;
    logic        mem_cs;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int total;
    int bad;
    int cyc;

    typedef struct {
        int          cyc;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic        is_l;
        logic        fault;
        logic [31:0] rdata;
    } ack_exp_t;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];

    prog_mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_ack     (f_ack),
        .f_rdata   (f_rdata),
        .f_fault   (f_fault),
        .l_req     (l_req),
        .l_we      (l_we),
        .l_addr    (l_addr),
        .l_wdata   (l_wdata),
        .l_ack     (l_ack),
        .l_rdata   (l_rdata),
        .l_fault   (l_fault),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input logic [9:0] off);
        pat = 32'h5A00_0000 | {22'h0, off};
    endfunction

    // Memory model: read data one cycle after a read strobe, junk otherwise
    always @(posedge clk) begin
        if (mem_cs && !mem_we) mem_rdata <= pat(mem_addr);
        else                   mem_rdata <= 32'hBAD0_0BAD;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every memory strobe and every ack against the scoreboard
    always @(negedge clk) begin
        mem_exp_t m;
        ack_exp_t a;
        if (mem_cs === 1'b1) begin
            if (mem_q.size() == 0) begin
                total++; bad++;
                $display("FAIL mem_cs_unexpected: got 1 want 0 (cyc %0d)", cyc);
            end else begin
                m = mem_q.pop_front();
                chk("mem_cyc", cyc, m.cyc);
                chk("mem_we", {31'h0, mem_we}, {31'h0, m.we});
                chk("mem_addr", {22'h0, mem_addr}, {22'h0, m.addr});
                chk("mem_wdata", mem_wdata, m.wdata);
                chk("busy_issue", {31'h0, busy}, 32'h1);
            end
        end
        if (f_ack === 1'b1 || l_ack === 1'b1) begin
            if (ack_q.size() == 0) begin
                total++; bad++;
                $display("FAIL ack_unexpected: got f=%b l=%b want none (cyc %0d)", f_ack, l_ack, cyc);
            end else begin
                a = ack_q.pop_front();
                chk("ack_cyc", cyc, a.cyc);
                chk("ack_who", {31'h0, l_ack}, {31'h0, a.is_l});
                chk("ack_both", {31'h0, f_ack & l_ack}, 32'h0);
                chk("ack_fault", {31'h0, (a.is_l ? l_fault : f_fault)}, {31'h0, a.fault});
                chk("ack_rdata", (a.is_l ? l_rdata : f_rdata), a.rdata);
                chk("busy_resp", {31'h0, busy}, 32'h1);
            end
        end
    end

    // Push expectations for a transaction sampled in cycle t
    task automatic expect_txn(input int t, input logic is_l, input logic we,
                              input logic [31:0] wdata, input logic ok, input logic [9:0] off);
        mem_exp_t m;
        ack_exp_t a;
        if (ok) begin
            m.cyc = t + 1; m.we = we; m.addr = off; m.wdata = wdata;
            mem_q.push_back(m);
        end
        a.cyc   = t + 2;
        a.is_l  = is_l;
        a.fault = !ok;
        a.rdata = (ok && !we) ? pat(off) : 32'h0;
        ack_q.push_back(a);
    endtask

    // One isolated transaction from IDLE; returns at the IDLE cycle after RESP
    task automatic txn(input logic is_l, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic ok, input logic [9:0] off);
        int t;
        @(negedge clk);
        t = cyc;
        if (is_l) begin
            l_req = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
        end else begin
            f_req = 1'b1; f_addr = addr;
        end
        expect_txn(t, is_l, we, wdata, ok, off);
        repeat (2) @(negedge clk);
        f_req = 1'b0; l_req = 1'b0; l_we = 1'b0; l_wdata = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        int t;
        int fi;
        int li;
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; f_req = 1'b0; f_addr = 32'h0; l_req = 1'b0; l_we = 1'b0;
        l_addr = 32'h0; l_wdata = 32'h0; mem_rdata = 32'h0;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_f_ack", {31'h0, f_ack}, 32'h0);
        chk("rst_l_ack", {31'h0, l_ack}, 32'h0);
        chk("rst_f_fault", {31'h0, f_fault}, 32'h0);
        chk("rst_l_fault", {31'h0, l_fault}, 32'h0);
        chk("rst_f_rdata", f_rdata, 32'h0);
        chk("rst_l_rdata", l_rdata, 32'h0);
        chk("rst_mem_cs", {31'h0, mem_cs}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", {22'h0, mem_addr}, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // basic fetch at window base
        txn(1'b0, 1'b0, 32'h0000_31B0, 32'h0, 1'b1, 10'h000);
        chk("idle_busy", {31'h0, busy}, 32'h0);

        // fetch faults: below window, above window, unaligned
        txn(1'b0, 1'b0, 32'h0000_31AC, 32'h0, 1'b0, 10'h000);
        txn(1'b0, 1'b0, 32'h0000_35B0, 32'h0, 1'b0, 10'h000);
        txn(1'b0, 1'b0, 32'h0000_31B2, 32'h0, 1'b0, 10'h000);

        // loader write, loader read at last word, loader write fault
        txn(1'b1, 1'b1, 32'h0000_3200, 32'hDEAD_BEEF, 1'b1, 10'h050);
        txn(1'b1, 1'b0, 32'h0000_35AC, 32'h0, 1'b1, 10'h3FC);
        txn(1'b1, 1'b1, 32'h0000_35B1, 32'h1234_5678, 1'b0, 10'h000);

        // fetch sweep over the whole window, req held, one txn per 3 cycles
        @(negedge clk);
        t = cyc;
        f_req = 1'b1;
        for (int i = 0; i < 256; i++) begin
            f_addr = 32'h0000_31B0 + 32'(i * 4);
            expect_txn(t, 1'b0, 1'b0, 32'h0, 1'b1, 10'(i * 4));
            repeat (2) @(negedge clk);
            if (i == 255) f_req = 1'b0;
            @(negedge clk);
            t = t + 3;
        end

        // both requesters held: F,F,F,F,L repeating
        @(negedge clk);
        t = cyc;
        fi = 0; li = 0;
        f_req = 1'b1; f_addr = 32'h0000_31B0;
        l_req = 1'b1; l_we = 1'b0; l_wdata = 32'h0; l_addr = 32'h0000_3400;
        for (int k = 0; k < 10; k++) begin
            if ((k % 5) == 4) begin
                expect_txn(t, 1'b1, 1'b0, 32'h0, 1'b1, 10'(32'h250 + 32'(li * 4)));
                li++;
            end else begin
                expect_txn(t, 1'b0, 1'b0, 32'h0, 1'b1, 10'(fi * 4));
                fi++;
            end
            repeat (2) @(negedge clk);
            f_addr = 32'h0000_31B0 + 32'(fi * 4);
            l_addr = 32'h0000_3400 + 32'(li * 4);
            if (k == 9) begin
                f_req = 1'b0; l_req = 1'b0;
            end
            @(negedge clk);
            t = t + 3;
        end

        // reset during ISSUE aborts; pending fetch then served normally
        @(negedge clk);
        t = cyc;
        f_req = 1'b1; f_addr = 32'h0000_3300;
        begin
            mem_exp_t m;
            m.cyc = t + 1; m.we = 1'b0; m.addr = 10'h150; m.wdata = 32'h0;
            mem_q.push_back(m);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_mem_cs", {31'h0, mem_cs}, 32'h0);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_f_ack", {31'h0, f_ack}, 32'h0);
        rst = 1'b0;
        expect_txn(cyc, 1'b0, 1'b0, 32'h0, 1'b1, 10'h150);
        repeat (2) @(negedge clk);
        f_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("mem_q_drained", mem_q.size(), 32'h0);
        chk("ack_q_drained", ack_q.size(), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
